ps2_event_fifo: RTL and testbench
=================================

// Module: ps2_event_fifo
// PURPOSE
// Parametrised successor to the PS/2 byte-to-word buffer. Takes the byte stream from the PS/2 receiver
// (tick + 8-bit data) and packs it into words of NBYTES bytes. Raw mode packs fixed-size words.
// Scan mode packs one complete scan-code event per word (E0/E1/F0 prefixes plus final code).
// Words queue in a FIFO_DEPTH-entry FIFO read by the I/O module through a valid/ready handshake.
// PARAMETERS
// NBYTES      4      bytes per output word (2..8); word width W = 8*NBYTES
// FIFO_DEPTH  4      output FIFO entries, power of 2 (2..16)
// TIMEOUT     50000  idle clk cycles after which a partial word is discarded (>=2)
// PORTS
// clk        in   1                      system clock, rising edge
// reset      in   1                      asynchronous, active-low reset
// tick       in   1                      1-cycle strobe: d holds a valid received byte
// d          in   8                      received byte
// rx_err     in   1                      1-cycle strobe: receiver parity/frame error
// mode       in   1                      0 = raw pack, 1 = scan-code event pack
// rd_ready   in   1                      consumer accepts head word this cycle
// clr_flags  in   1                      clears ovf/err/tmo
// listo      out  1                      FIFO non-empty (head word valid)
// joi        out  W                      head word
// len        out  $clog2(NBYTES+1)       valid byte count of head word (1..NBYTES)
// fill       out  $clog2(FIFO_DEPTH+1)   FIFO occupancy
// busy       out  1                      partial word being assembled
// ovf        out  1                      sticky: a completed word was dropped because FIFO was full
// err        out  1                      sticky: rx_err discarded a partial word
// tmo        out  1                      sticky: timeout discarded a partial word
// BEHAVIOUR
// - Reset (async, reset=0): FIFO empty, all outputs 0, assembler state IDLE, byte count 0, timer 0.
// - Assembler FSM has two states:
//     IDLE: no partial word. A tick latches mode into mode_q, loads the byte, and moves to ACC.
//     ACC:  partial word held. Each tick appends a byte. A word completes as follows:
//           raw  -> byte count reaches NBYTES
//           scan -> byte is not E0/E1/F0, OR byte count reaches NBYTES
//           On completion: push and return to IDLE.
// - mode changes while in ACC have no effect until the next word; mode_q governs the word in progress.
// - Packing: bytes shift in from the right. The first byte ends up most significant and the last
//   byte sits at joi[7:0]. Unused upper bytes are 0, so scan E0 F0 75 gives 0x00E0F075 with len=3.
// - Scan mode, single byte with no prefix (e.g. 1C): completes immediately, len=1.
// - Push latency: the word is visible on joi/listo the cycle after the completing tick.
// - Handshake: a pop occurs when listo & rd_ready. joi/len stay stable until popped.
// - Full FIFO + push, no pop: word dropped, FIFO contents unchanged, ovf<=1.
// - Full FIFO + push + pop in the same cycle: both succeed; fill stays FIFO_DEPTH.
// - Empty FIFO + rd_ready: no effect.
// - Timeout timer: reset to 0 on each tick and counts while in ACC. At TIMEOUT-1 the partial word
//   is discarded, state goes to IDLE and tmo<=1. No push occurs.
// - rx_err in ACC: partial word discarded, IDLE, err<=1.
// - rx_err in IDLE: err<=1 only.
// - rx_err and tick in the same cycle: rx_err wins and the byte is ignored.
// - clr_flags clears ovf/err/tmo. If a set condition occurs in the same cycle, set wins.
// - busy = (state==ACC). fill is registered and matches FIFO contents.
// - FIFO pointers wrap modulo FIFO_DEPTH. An extra pointer bit distinguishes full from empty.
// TESTING
// 1 raw, ticks 12,34,56,78 -> 1 cycle after 4th tick: listo=1, joi=0x12345678, len=4, fill=1.
// 2 scan, ticks E0,F0,75 then 1C -> first word 0x00E0F075 len=3, then 0x0000001C len=1, fill=2.
// 3 no rd_ready, push 5 raw words (depth 4) -> fill=4, ovf=1, head still word 1;
//   then pop all -> words 1..4 in order.
// 4 fill=4, push on the same cycle as a pop -> fill stays 4, ovf=0, new word appears last.
// 5 raw, ticks AA,BB then idle TIMEOUT cycles -> busy=0, tmo=1, fill=0; next 4 bytes form a clean word.
// 6 rx_err after 2 bytes, and reset asserted mid-word -> partial discarded with err=1;
//   after reset all outputs are 0.

Source files
------------

// File: rtl/ps2_event_fifo.sv
// Packs the PS/2 receiver byte stream into raw or scan-code-event words
// and queues them in a small FIFO read through a valid/ready handshake.
module ps2_event_fifo #(
   parameter int NBYTES     = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 50000
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              tick,
   input  logic [7:0]                        d,
   input  logic                              rx_err,
   input  logic                              mode,
   input  logic                              rd_ready,
   input  logic                              clr_flags,
   output logic                              listo,
   output logic [8*NBYTES-1:0]               joi,
   output logic [$clog2(NBYTES+1)-1:0]       len,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fill,
   output logic                              busy,
   output logic                              ovf,
   output logic                              err,
   output logic                              tmo
);

   localparam int W  = 8 * NBYTES;
   localparam int LW = $clog2(NBYTES + 1);
   localparam int FW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

   state_t        state, state_nxt;
   logic [W-9:0]  acc, base;
   logic [W-1:0]  word_nxt;
   logic [LW-1:0] cnt, cnt_nxt;
   logic [TW-1:0] timer;
   logic          mode_q, eff_mode, is_prefix, take, complete, timeout_hit;
   logic          do_push, do_pop, full;
   logic [PW:0]   wr_ptr, rd_ptr;
   logic [W-1:0]  mem_word [FIFO_DEPTH];
   logic [LW-1:0] mem_len  [FIFO_DEPTH];

   // Handshake: a word transfers on any rising edge where listo & rd_ready;
   // joi/len hold the head word unchanged until that transfer.

   // The first byte of a word is judged with the live mode input, later ones with mode_q.
   always_comb begin
      take        = tick & ~rx_err;
      eff_mode    = (state == IDLE) ? mode : mode_q;
      is_prefix   = (d == 8'hE0) | (d == 8'hE1) | (d == 8'hF0);
      base        = (state == IDLE) ? '0 : acc;
      word_nxt    = {base, d};
      cnt_nxt     = (state == IDLE) ? LW'(1) : cnt + LW'(1);
      complete    = take & ((cnt_nxt == LW'(NBYTES)) | (eff_mode & ~is_prefix));
      timeout_hit = (state == ACC) & ~rx_err & ~tick & (timer == TW'(TIMEOUT - 1));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (take && !complete) state_nxt = ACC;
         ACC:     if (rx_err || complete || timeout_hit) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == ACC);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc    <= '0;
         cnt    <= '0;
         timer  <= '0;
         mode_q <= 1'b0;
      end else if (take) begin
         acc   <= word_nxt[W-9:0];
         cnt   <= complete ? '0 : cnt_nxt;
         timer <= '0;
         if (state == IDLE) mode_q <= mode;
      end else if (rx_err || timeout_hit) begin
         cnt   <= '0;
         timer <= '0;
      end else if (state == ACC) begin
         timer <= timer + TW'(1);
      end
   end

   // Full/empty come from the pointers' extra wrap bit; fill is kept alongside for the consumer.
   always_comb begin
      full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
      listo   = (wr_ptr != rd_ptr);
      do_pop  = listo & rd_ready;
      do_push = complete & (~full | do_pop);
      joi     = listo ? mem_word[rd_ptr[PW-1:0]] : '0;
      len     = listo ? mem_len[rd_ptr[PW-1:0]]  : '0;
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_word[wr_ptr[PW-1:0]] <= word_nxt;
         mem_len[wr_ptr[PW-1:0]]  <= cnt_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
         case ({do_push, do_pop})
            2'b10:   fill <= fill + FW'(1);
            2'b01:   fill <= fill - FW'(1);
            default: fill <= fill;
         endcase
      end
   end

   // Sticky flags: a set in the same cycle as clr_flags wins.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ovf <= 1'b0;
         err <= 1'b0;
         tmo <= 1'b0;
      end else begin
         ovf <= (complete & full & ~do_pop) | (ovf & ~clr_flags);
         err <= rx_err | (err & ~clr_flags);
         tmo <= timeout_hit | (tmo & ~clr_flags);
      end
   end

endmodule

// File: tb/tb_ps2_event_fifo.sv
// Self-checking bench for ps2_event_fifo: directed scenarios plus a randomized
// run compared every cycle against a byte-list/queue model of the block.
module tb_ps2_event_fifo;

   localparam int NB    = 4;
   localparam int DEPTH = 4;
   localparam int TMO   = 20;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        tick = 1'b0;
   logic [7:0]  d = '0;
   logic        rx_err = 1'b0;
   logic        mode = 1'b0;
   logic        rd_ready = 1'b0;
   logic        clr_flags = 1'b0;
   logic        listo, busy, ovf, err, tmo;
   logic [31:0] joi;
   logic [2:0]  len;
   logic [2:0]  fill;
   logic [42:0] dut_stat;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [31:0] exp_q[$];
   logic [2:0]  len_q[$];
   logic [7:0]  part_q[$];
   bit          m_mode, m_ovf, m_err, m_tmo;
   int          idle_cnt;

   ps2_event_fifo #(.NBYTES(NB), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .tick(tick), .d(d), .rx_err(rx_err), .mode(mode),
      .rd_ready(rd_ready), .clr_flags(clr_flags), .listo(listo), .joi(joi), .len(len),
      .fill(fill), .busy(busy), .ovf(ovf), .err(err), .tmo(tmo)
   );

   always #5 clk = ~clk;

   assign dut_stat = {listo, fill, busy, ovf, err, tmo, len, joi};

   function automatic logic [42:0] exp_status();
      logic [31:0] j = '0;
      logic [2:0]  l = '0;
      if (exp_q.size() > 0) begin
         j = exp_q[0];
         l = len_q[0];
      end
      return {exp_q.size() > 0, 3'(exp_q.size()), part_q.size() > 0, m_ovf, m_err, m_tmo, l, j};
   endfunction

   // One clock of the behavioural model, evaluated on the inputs of that cycle.
   task automatic model_step(input bit t, input logic [7:0] dd, input bit e, input bit m,
                             input bit r, input bit c);
      bit          pop, push, s_ovf, s_err, s_tmo;
      logic [31:0] w;
      logic [2:0]  n;
      pop = r && (exp_q.size() > 0);
      push = 0; s_ovf = 0; s_err = 0; s_tmo = 0; w = '0; n = '0;
      if (e) begin
         s_err = 1;
         part_q.delete();
         idle_cnt = 0;
      end else if (t) begin
         if (part_q.size() == 0) m_mode = m;
         part_q.push_back(dd);
         idle_cnt = 0;
         if (part_q.size() == NB ||
             (m_mode && !(dd == 8'hE0 || dd == 8'hE1 || dd == 8'hF0))) begin
            foreach (part_q[i]) w = (w << 8) | 32'(part_q[i]);
            n = 3'(part_q.size());
            push = 1;
            part_q.delete();
         end
      end else if (part_q.size() > 0) begin
         idle_cnt++;
         if (idle_cnt == TMO) begin
            part_q.delete();
            idle_cnt = 0;
            s_tmo = 1;
         end
      end
      if (pop) begin
         void'(exp_q.pop_front());
         void'(len_q.pop_front());
      end
      if (push) begin
         if (exp_q.size() < DEPTH) begin
            exp_q.push_back(w);
            len_q.push_back(n);
         end else s_ovf = 1;
      end
      if (c) begin m_ovf = 0; m_err = 0; m_tmo = 0; end
      if (s_ovf) m_ovf = 1;
      if (s_err) m_err = 1;
      if (s_tmo) m_tmo = 1;
   endtask

   task automatic drive(input bit t, input logic [7:0] dd, input bit e, input bit m,
                        input bit r, input bit c);
      tick = t; d = dd; rx_err = e; mode = m; rd_ready = r; clr_flags = c;
      model_step(t, dd, e, m, r, c);
      @(posedge clk);
      #1;
      tick = 0; rx_err = 0; rd_ready = 0; clr_flags = 0;
   endtask

   task automatic model_clear();
      exp_q.delete(); len_q.delete(); part_q.delete();
      m_mode = 0; m_ovf = 0; m_err = 0; m_tmo = 0; idle_cnt = 0;
   endtask

   task automatic do_reset();
      reset = 0; tick = 0; d = '0; rx_err = 0; mode = 0; rd_ready = 0; clr_flags = 0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      reset = 1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (dut_stat !== 43'd0) begin
         errors++;
         $display("FAIL reset_state: got %h want 0", dut_stat);
      end
   endtask

   task automatic test_raw();
      do_reset();
      drive(1, 8'h12, 0, 0, 0, 0);
      drive(1, 8'h34, 0, 0, 0, 0);
      drive(1, 8'h56, 0, 0, 0, 0);
      checks++;
      if (listo !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL raw_partial: listo=%b busy=%b want 0/1", listo, busy);
      end
      drive(1, 8'h78, 0, 0, 0, 0);
      checks++;
      if ({listo, joi, len, fill} !== {1'b1, 32'h12345678, 3'd4, 3'd1}) begin
         errors++;
         $display("FAIL raw_word: listo=%b joi=%h len=%0d fill=%0d want 1/12345678/4/1",
                  listo, joi, len, fill);
      end
      drive(0, 8'h00, 0, 0, 1, 0);
      checks++;
      if (dut_stat !== exp_status()) begin
         errors++;
         $display("FAIL raw_pop: got %h want %h", dut_stat, exp_status());
      end
   endtask

   task automatic test_scan();
      do_reset();
      drive(1, 8'hE0, 0, 1, 0, 0);
      drive(1, 8'hF0, 0, 1, 0, 0);
      drive(1, 8'h75, 0, 1, 0, 0);
      checks++;
      if ({listo, joi, len, busy} !== {1'b1, 32'h00E0F075, 3'd3, 1'b0}) begin
         errors++;
         $display("FAIL scan_break: joi=%h len=%0d busy=%b want 00e0f075/3/0", joi, len, busy);
      end
      drive(1, 8'h1C, 0, 1, 0, 0);
      checks++;
      if ({fill, joi} !== {3'd2, 32'h00E0F075}) begin
         errors++;
         $display("FAIL scan_two: fill=%0d joi=%h want 2/00e0f075", fill, joi);
      end
      drive(0, 8'h00, 0, 1, 1, 0);
      checks++;
      if ({joi, len, fill} !== {32'h0000001C, 3'd1, 3'd1}) begin
         errors++;
         $display("FAIL scan_single: joi=%h len=%0d fill=%0d want 0000001c/1/1", joi, len, fill);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] words[5];
      do_reset();
      for (int w = 0; w < 5; w++) begin
         words[w] = '0;
         for (int b = 0; b < NB; b++) begin
            words[w] = (words[w] << 8) | 32'((w + 1) * 16 + b);
            drive(1, 8'((w + 1) * 16 + b), 0, 0, 0, 0);
         end
      end
      checks++;
      if ({fill, ovf, joi} !== {3'd4, 1'b1, words[0]}) begin
         errors++;
         $display("FAIL ovf_full: fill=%0d ovf=%b joi=%h want 4/1/%h", fill, ovf, joi, words[0]);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (joi !== words[i]) begin
            errors++;
            $display("FAIL ovf_order%0d: joi=%h want %h", i, joi, words[i]);
         end
         drive(0, 8'h00, 0, 0, 1, 0);
      end
      checks++;
      if ({listo, fill} !== 4'd0) begin
         errors++;
         $display("FAIL ovf_drain: listo=%b fill=%0d want 0/0", listo, fill);
      end
   endtask

   task automatic test_push_pop();
      do_reset();
      for (int w = 0; w < 4; w++)
         for (int b = 0; b < NB; b++) drive(1, 8'(w * 4 + b), 0, 0, 0, 0);
      drive(1, 8'hA1, 0, 0, 0, 0);
      drive(1, 8'hA2, 0, 0, 0, 0);
      drive(1, 8'hA3, 0, 0, 0, 0);
      drive(1, 8'hA4, 0, 0, 1, 0);
      checks++;
      if ({fill, ovf} !== {3'd4, 1'b0} || dut_stat !== exp_status()) begin
         errors++;
         $display("FAIL push_pop_full: fill=%0d ovf=%b stat=%h want 4/0/%h",
                  fill, ovf, dut_stat, exp_status());
      end
      repeat (3) drive(0, 8'h00, 0, 0, 1, 0);
      checks++;
      if ({fill, joi} !== {3'd1, 32'hA1A2A3A4}) begin
         errors++;
         $display("FAIL push_pop_last: fill=%0d joi=%h want 1/a1a2a3a4", fill, joi);
      end
      drive(0, 8'h00, 0, 0, 1, 0);
      drive(0, 8'h00, 0, 0, 1, 0);
      checks++;
      if (dut_stat !== 43'd0) begin
         errors++;
         $display("FAIL empty_ready: got %h want 0", dut_stat);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      drive(1, 8'hAA, 0, 0, 0, 0);
      drive(1, 8'hBB, 0, 0, 0, 0);
      repeat (TMO - 1) drive(0, 8'h00, 0, 0, 0, 0);
      checks++;
      if ({busy, tmo} !== 2'b10) begin
         errors++;
         $display("FAIL tmo_edge: busy=%b tmo=%b want 1/0", busy, tmo);
      end
      drive(0, 8'h00, 0, 0, 0, 0);
      checks++;
      if ({busy, tmo, fill} !== {1'b0, 1'b1, 3'd0}) begin
         errors++;
         $display("FAIL tmo_fire: busy=%b tmo=%b fill=%0d want 0/1/0", busy, tmo, fill);
      end
      drive(1, 8'h01, 0, 0, 0, 0);
      drive(1, 8'h02, 0, 0, 0, 0);
      drive(1, 8'h03, 0, 0, 0, 0);
      drive(1, 8'h04, 0, 0, 0, 0);
      checks++;
      if ({joi, len, fill, tmo} !== {32'h01020304, 3'd4, 3'd1, 1'b1}) begin
         errors++;
         $display("FAIL tmo_clean: joi=%h len=%0d fill=%0d tmo=%b want 01020304/4/1/1",
                  joi, len, fill, tmo);
      end
      drive(0, 8'h00, 0, 0, 0, 1);
      checks++;
      if (tmo !== 1'b0) begin
         errors++;
         $display("FAIL tmo_clear: tmo=%b want 0", tmo);
      end
   endtask

   task automatic test_rx_err();
      do_reset();
      drive(1, 8'hAA, 0, 0, 0, 0);
      drive(1, 8'hBB, 0, 0, 0, 0);
      drive(0, 8'h00, 1, 0, 0, 0);
      checks++;
      if ({busy, err, fill} !== {1'b0, 1'b1, 3'd0}) begin
         errors++;
         $display("FAIL err_discard: busy=%b err=%b fill=%0d want 0/1/0", busy, err, fill);
      end
      drive(1, 8'h55, 1, 1, 0, 0);
      checks++;
      if ({busy, listo} !== 2'b00) begin
         errors++;
         $display("FAIL err_wins_tick: busy=%b listo=%b want 0/0", busy, listo);
      end
      drive(0, 8'h00, 1, 0, 0, 1);
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL err_set_wins: err=%b want 1", err);
      end
      drive(0, 8'h00, 0, 0, 0, 1);
      drive(1, 8'h1C, 0, 1, 0, 0);
      drive(1, 8'h11, 0, 0, 0, 0);
      drive(1, 8'h22, 0, 0, 0, 0);
      checks++;
      if ({err, busy, fill} !== {1'b0, 1'b1, 3'd1}) begin
         errors++;
         $display("FAIL err_pre_reset: err=%b busy=%b fill=%0d want 0/1/1", err, busy, fill);
      end
      #1 reset = 0;
      #1;
      checks++;
      if (dut_stat !== 43'd0) begin
         errors++;
         $display("FAIL async_reset: got %h want 0", dut_stat);
      end
      model_clear();
   endtask

   task automatic test_random();
      logic [7:0] pfx[3];
      logic [7:0] b;
      bit         m, t;
      int         tick_pct;
      pfx[0] = 8'hE0; pfx[1] = 8'hE1; pfx[2] = 8'hF0;
      do_reset();
      m = 0;
      for (int cyc = 0; cyc < 1200; cyc++) begin
         case ((cyc / 100) % 3)
            0:       tick_pct = 70;
            1:       tick_pct = 15;
            default: tick_pct = 2;
         endcase
         if ($urandom_range(0, 99) < 5) m = ~m;
         t = ($urandom_range(0, 99) < tick_pct);
         b = ($urandom_range(0, 99) < 40) ? pfx[$urandom_range(0, 2)] : 8'($urandom_range(0, 255));
         drive(t, b, $urandom_range(0, 99) < 2, m, $urandom_range(0, 99) < 35,
               $urandom_range(0, 99) < 4);
         checks++;
         if (dut_stat !== exp_status()) begin
            errors++;
            $display("FAIL random_cycle%0d: got %h want %h", cyc, dut_stat, exp_status());
         end
      end
   endtask

   initial begin
      test_reset();
      test_raw();
      test_scan();
      test_overflow();
      test_push_pop();
      test_timeout();
      test_rx_err();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
